// File: rtl/fma_array.sv
// ----------------------------------------------------------------------------
// fma_array
//   LANES-wide signed fixed-point fused multiply-add with saturation.
//   Each lane computes out = round(a * b) + addend, where the addend is either
//   c_in or the lane's own current result (accumulate mode). The datapath is a
//   two-stage pipeline: stage 1 registers the full-width product, stage 2
//   rounds, adds, clamps and updates the result register.
//
// Ports
//   clk_in      clock
//   rst_in      synchronous reset, active high
//   a_in        multiplicand vector (lane i at [i*WIDTH +: WIDTH])
//   b_in        multiplier vector
//   c_in        addend vector
//   a_valid_in  load a_in into the held operand register; use a_in directly
//   b_valid_in  load b_in into the held operand register; use b_in directly
//   c_valid_in  addend = c_in when high, otherwise the lane's current result
//   compute_in  start one FMA on all lanes this cycle
//   clear_in    zero results and flush the pipeline
//   out         registered results
//   valid_out   one-cycle pulse when out was updated
//   sat_out     per-lane flag: the last result was clamped
// ----------------------------------------------------------------------------
module fma_array #(
    parameter int WIDTH       = 16,
    parameter int FIXED_POINT = 10,
    parameter int LANES       = 4
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic [LANES*WIDTH-1:0]   a_in,
    input  logic [LANES*WIDTH-1:0]   b_in,
    input  logic [LANES*WIDTH-1:0]   c_in,
    input  logic                     a_valid_in,
    input  logic                     b_valid_in,
    input  logic                     c_valid_in,
    input  logic                     compute_in,
    input  logic                     clear_in,
    output logic [LANES*WIDTH-1:0]   out,
    output logic                     valid_out,
    output logic [LANES-1:0]         sat_out
);

    localparam int PW = 2 * WIDTH;   // full product width
    localparam int XW = PW + 1;      // extended width for round/add, cannot overflow

    // Half an LSB of the result, added before the arithmetic shift (round half up).
    localparam logic signed [XW-1:0] ROUND_HALF =
        {{(XW-1){1'b0}}, 1'b1} << (FIXED_POINT - 1);
    localparam logic signed [XW-1:0] SAT_MAX =
        {{(WIDTH+2){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [XW-1:0] SAT_MIN =
        {{(WIDTH+2){1'b1}}, {(WIDTH-1){1'b0}}};

    // Held operands
    logic [LANES*WIDTH-1:0]  r_a;
    logic [LANES*WIDTH-1:0]  r_b;

    // Stage 1 registers
    logic signed [PW-1:0]    r_p1 [LANES];
    logic [LANES*WIDTH-1:0]  r_c1;
    logic                    r_use_acc1;
    logic                    r_v1;

    // Stage 2 / output registers
    logic [LANES*WIDTH-1:0]  r_out;
    logic                    r_valid;
    logic [LANES-1:0]        r_sat;

    // Combinational datapath
    logic [LANES*WIDTH-1:0]  w_op_a;
    logic [LANES*WIDTH-1:0]  w_op_b;
    logic signed [PW-1:0]    w_prod [LANES];
    logic signed [XW-1:0]    w_pext [LANES];
    logic signed [XW-1:0]    w_rnd  [LANES];
    logic [WIDTH-1:0]        w_add  [LANES];
    logic signed [XW-1:0]    w_sum  [LANES];
    logic [LANES*WIDTH-1:0]  w_res;
    logic [LANES-1:0]        w_sat;

    // Same-cycle operand data takes precedence over the held copy.
    assign w_op_a = a_valid_in ? a_in : r_a;
    assign w_op_b = b_valid_in ? b_in : r_b;

    assign out       = r_out;
    assign valid_out = r_valid;
    assign sat_out   = r_sat;

    // Per-lane signed product feeding stage 1.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            w_prod[i] = $signed(w_op_a[i*WIDTH +: WIDTH]) * $signed(w_op_b[i*WIDTH +: WIDTH]);
        end
    end

    // Stage 2: round the product, add the selected addend, clamp to WIDTH bits.
    always_comb begin
        w_res = '0;
        w_sat = '0;
        for (int i = 0; i < LANES; i++) begin
            w_pext[i] = {r_p1[i][PW-1], r_p1[i]};
            w_rnd[i]  = (w_pext[i] + ROUND_HALF) >>> FIXED_POINT;
            // Accumulate reads the result register as it stands before this edge,
            // which is exactly the predecessor's result for back-to-back ops.
            if (r_use_acc1) begin
                w_add[i] = r_out[i*WIDTH +: WIDTH];
            end else begin
                w_add[i] = r_c1[i*WIDTH +: WIDTH];
            end
            w_sum[i] = w_rnd[i] + {{(WIDTH+1){w_add[i][WIDTH-1]}}, w_add[i]};
            if (w_sum[i] > SAT_MAX) begin
                w_res[i*WIDTH +: WIDTH] = SAT_MAX[WIDTH-1:0];
                w_sat[i]                = 1'b1;
            end else if (w_sum[i] < SAT_MIN) begin
                w_res[i*WIDTH +: WIDTH] = SAT_MIN[WIDTH-1:0];
                w_sat[i]                = 1'b1;
            end else begin
                w_res[i*WIDTH +: WIDTH] = w_sum[i][WIDTH-1:0];
                w_sat[i]                = 1'b0;
            end
        end
    end

    // Held operand registers; they load whenever their valid is high, even during clear.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_a <= '0;
            r_b <= '0;
        end else begin
            if (a_valid_in) begin
                r_a <= a_in;
            end else begin
                r_a <= r_a;
            end
            if (b_valid_in) begin
                r_b <= b_in;
            end else begin
                r_b <= r_b;
            end
        end
    end

    // Stage 1 capture; clear drops a compute request issued in the same cycle.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < LANES; i++) begin
                r_p1[i] <= '0;
            end
            r_c1       <= '0;
            r_use_acc1 <= 1'b0;
            r_v1       <= 1'b0;
        end else if (clear_in) begin
            r_v1       <= 1'b0;
        end else if (compute_in) begin
            for (int i = 0; i < LANES; i++) begin
                r_p1[i] <= w_prod[i];
            end
            r_c1       <= c_in;
            r_use_acc1 <= ~c_valid_in;
            r_v1       <= 1'b1;
        end else begin
            r_v1       <= 1'b0;
        end
    end

    // Stage 2 result update; clear discards any op currently in stage 2.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_out   <= '0;
            r_sat   <= '0;
            r_valid <= 1'b0;
        end else if (clear_in) begin
            r_out   <= '0;
            r_sat   <= '0;
            r_valid <= 1'b0;
        end else if (r_v1) begin
            r_out   <= w_res;
            r_sat   <= w_sat;
            r_valid <= 1'b1;
        end else begin
            r_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fma_array.sv
module tb_fma_array;

    localparam int W  = 16;
    localparam int FP = 10;
    localparam int L  = 4;

    logic             clk_in = 1'b0;
    logic             rst_in;
    logic [L*W-1:0]   a_in, b_in, c_in;
    logic             a_valid_in, b_valid_in, c_valid_in;
    logic             compute_in, clear_in;
    logic [L*W-1:0]   out;
    logic             valid_out;
    logic [L-1:0]     sat_out;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [L*W-1:0]   m_a, m_b, m_out;
    logic [L-1:0]     m_sat;
    logic             m_valid;
    logic             p_v, p_acc;
    logic [L*W-1:0]   p_a, p_b, p_c;

    fma_array #(.WIDTH(W), .FIXED_POINT(FP), .LANES(L)) dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .a_in       (a_in),
        .b_in       (b_in),
        .c_in       (c_in),
        .a_valid_in (a_valid_in),
        .b_valid_in (b_valid_in),
        .c_valid_in (c_valid_in),
        .compute_in (compute_in),
        .clear_in   (clear_in),
        .out        (out),
        .valid_out  (valid_out),
        .sat_out    (sat_out)
    );

    always #5 clk_in = ~clk_in;

    // One lane of the FMA using plain integer arithmetic: {sat, result}.
    function automatic logic [16:0] lane_ref(input logic [15:0] a, input logic [15:0] b,
                                             input logic [15:0] addend);
        longint p, r, s;
        p = longint'($signed(a)) * longint'($signed(b));
        r = (p + 64'sd512) >>> FP;          // floor((p + 0.5 LSB) / 2^FP)
        s = r + longint'($signed(addend));
        if (s > 64'sd32767)       return {1'b1, 16'h7FFF};
        else if (s < -64'sd32768) return {1'b1, 16'h8000};
        else                      return {1'b0, s[15:0]};
    endfunction

    function automatic logic [L*W-1:0] rep4(input logic [15:0] v);
        return {v, v, v, v};
    endfunction

    function automatic logic [L*W-1:0] rnd_vec();
        return {$urandom, $urandom};
    endfunction

    task automatic idle_inputs();
        rst_in = 1'b0; clear_in = 1'b0; compute_in = 1'b0;
        a_valid_in = 1'b0; b_valid_in = 1'b0; c_valid_in = 1'b0;
        a_in = rnd_vec(); b_in = rnd_vec(); c_in = rnd_vec();
    endtask

    // Advance one clock: update the model with the current inputs, then step the DUT.
    task automatic tick();
        logic [L*W-1:0] opa, opb;
        logic [16:0]    rr;
        logic [15:0]    add;
        opa = a_valid_in ? a_in : m_a;
        opb = b_valid_in ? b_in : m_b;
        if (rst_in) begin
            m_a = '0; m_b = '0; m_out = '0; m_sat = '0; m_valid = 1'b0; p_v = 1'b0;
        end else begin
            if (a_valid_in) m_a = a_in;
            if (b_valid_in) m_b = b_in;
            if (clear_in) begin
                m_out = '0; m_sat = '0; m_valid = 1'b0; p_v = 1'b0;
            end else begin
                if (p_v) begin
                    for (int i = 0; i < L; i++) begin
                        add = p_acc ? m_out[i*W +: W] : p_c[i*W +: W];
                        rr  = lane_ref(p_a[i*W +: W], p_b[i*W +: W], add);
                        m_out[i*W +: W] = rr[15:0];
                        m_sat[i]        = rr[16];
                    end
                end
                m_valid = p_v;
                p_v   = compute_in;
                p_a   = opa;
                p_b   = opb;
                p_c   = c_in;
                p_acc = ~c_valid_in;
            end
        end
        @(posedge clk_in);
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_in = 1'b1;
        tick();
        tick();
        n_checks++;
        if (out !== 64'h0 || valid_out !== 1'b0 || sat_out !== 4'h0) begin
            n_errors++;
            $display("FAIL reset: out=%h valid=%b sat=%b required out=0 valid=0 sat=0",
                     out, valid_out, sat_out);
        end
        idle_inputs();
    endtask

    task automatic test_basic();
        idle_inputs();
        a_in = rep4(16'h0600); b_in = rep4(16'h0800); c_in = rep4(16'h0100);
        a_valid_in = 1'b1; b_valid_in = 1'b1; c_valid_in = 1'b1; compute_in = 1'b1;
        tick();
        n_checks++;
        if (valid_out !== 1'b0) begin
            n_errors++;
            $display("FAIL basic_early_valid: valid=%b required 0", valid_out);
        end
        idle_inputs();
        tick();
        n_checks++;
        if (valid_out !== 1'b1 || out !== rep4(16'h0D00) || sat_out !== 4'h0) begin
            n_errors++;
            $display("FAIL basic_result: out=%h valid=%b sat=%b required out=%h valid=1 sat=0",
                     out, valid_out, sat_out, rep4(16'h0D00));
        end
        tick();
        n_checks++;
        if (valid_out !== 1'b0 || out !== rep4(16'h0D00)) begin
            n_errors++;
            $display("FAIL basic_pulse: out=%h valid=%b required out held, valid=0", out, valid_out);
        end
    endtask

    task automatic test_mac();
        logic [15:0] exp_seq [4];
        exp_seq[0] = 16'h0200; exp_seq[1] = 16'h0400; exp_seq[2] = 16'h0600; exp_seq[3] = 16'h0800;
        idle_inputs();
        clear_in = 1'b1;
        tick();
        idle_inputs();
        a_in = rep4(16'h0400); b_in = rep4(16'h0200); a_valid_in = 1'b1; b_valid_in = 1'b1;
        tick();
        for (int k = 0; k < 5; k++) begin
            idle_inputs();
            compute_in = (k < 4) ? 1'b1 : 1'b0;
            tick();
            if (k >= 1) begin
                n_checks++;
                if (valid_out !== 1'b1 || out !== rep4(exp_seq[k-1])) begin
                    n_errors++;
                    $display("FAIL mac_step%0d: out=%h valid=%b required out=%h valid=1",
                             k - 1, out, valid_out, rep4(exp_seq[k-1]));
                end
            end
        end
    endtask

    task automatic test_saturation_rounding();
        idle_inputs();
        a_in = {16'h0001, 16'hFA00, 16'hB000, 16'h5000};
        b_in = {16'h0200, 16'h0800, 16'h5000, 16'h5000};
        c_in = 64'h0;
        a_valid_in = 1'b1; b_valid_in = 1'b1; c_valid_in = 1'b1; compute_in = 1'b1;
        tick();
        idle_inputs();
        a_in = {16'hFFFF, 16'h0001, 16'hFFFF, 16'h0001};
        b_in = {16'h0201, 16'h01FF, 16'h0200, 16'h0200};
        c_in = 64'h0;
        a_valid_in = 1'b1; b_valid_in = 1'b1; c_valid_in = 1'b1; compute_in = 1'b1;
        tick();
        n_checks++;
        if (out !== {16'h0001, 16'hF400, 16'h8000, 16'h7FFF} || sat_out !== 4'b0011 ||
            valid_out !== 1'b1) begin
            n_errors++;
            $display("FAIL saturation: out=%h sat=%b valid=%b required out=0001f40080007fff sat=0011 valid=1",
                     out, sat_out, valid_out);
        end
        idle_inputs();
        tick();
        n_checks++;
        if (out !== {16'hFFFF, 16'h0000, 16'h0000, 16'h0001} || sat_out !== 4'b0000) begin
            n_errors++;
            $display("FAIL rounding: out=%h sat=%b required out=ffff000000000001 sat=0000",
                     out, sat_out);
        end
    endtask

    task automatic test_held_operands();
        idle_inputs();
        a_in = rep4(16'h0800); a_valid_in = 1'b1;
        tick();
        idle_inputs();
        tick();
        idle_inputs();
        b_in = rep4(16'h0C00); b_valid_in = 1'b1; c_in = 64'h0; c_valid_in = 1'b1;
        compute_in = 1'b1;
        tick();
        idle_inputs();
        a_in = rep4(16'h0400); a_valid_in = 1'b1; c_in = 64'h0; c_valid_in = 1'b1;
        compute_in = 1'b1;
        tick();
        n_checks++;
        if (out !== rep4(16'h1800) || valid_out !== 1'b1) begin
            n_errors++;
            $display("FAIL held_a: out=%h valid=%b required out=%h valid=1",
                     out, valid_out, rep4(16'h1800));
        end
        idle_inputs();
        tick();
        n_checks++;
        if (out !== rep4(16'h0C00) || valid_out !== 1'b1) begin
            n_errors++;
            $display("FAIL same_cycle_a: out=%h valid=%b required out=%h valid=1",
                     out, valid_out, rep4(16'h0C00));
        end
    endtask

    // use_rst selects reset vs clear as the aborting control.
    task automatic test_abort(input logic use_rst);
        idle_inputs();
        a_in = rep4(16'h0400); b_in = rep4(16'h0400); c_in = rep4(16'h0000);
        a_valid_in = 1'b1; b_valid_in = 1'b1; c_valid_in = 1'b1; compute_in = 1'b1;
        tick();
        idle_inputs();
        tick();
        n_checks++;
        if (out !== rep4(16'h0400)) begin
            n_errors++;
            $display("FAIL abort_setup(rst=%0b): out=%h required %h", use_rst, out, rep4(16'h0400));
        end
        idle_inputs();
        compute_in = 1'b1;
        tick();
        idle_inputs();
        if (use_rst) rst_in = 1'b1;
        else         clear_in = 1'b1;
        compute_in = 1'b1;
        tick();
        idle_inputs();
        n_checks++;
        if (out !== 64'h0 || valid_out !== 1'b0 || sat_out !== 4'h0) begin
            n_errors++;
            $display("FAIL abort(rst=%0b): out=%h valid=%b sat=%b required 0/0/0",
                     use_rst, out, valid_out, sat_out);
        end
        tick();
        n_checks++;
        if (valid_out !== 1'b0 || out !== 64'h0) begin
            n_errors++;
            $display("FAIL abort_no_pulse(rst=%0b): out=%h valid=%b required out=0 valid=0",
                     use_rst, out, valid_out);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            idle_inputs();
            rst_in     = ($urandom_range(0, 59) == 0);
            clear_in   = ($urandom_range(0, 29) == 0);
            compute_in = ($urandom_range(0, 9) < 7);
            a_valid_in = $urandom_range(0, 1);
            b_valid_in = $urandom_range(0, 1);
            c_valid_in = $urandom_range(0, 1);
            if ($urandom_range(0, 1) == 1) begin
                // small operands keep accumulation out of saturation for a while
                for (int i = 0; i < L; i++) begin
                    a_in[i*W +: W] = 16'($signed(12'($urandom)));
                    b_in[i*W +: W] = 16'($signed(12'($urandom)));
                end
            end
            tick();
            n_checks++;
            if (out !== m_out || valid_out !== m_valid || sat_out !== m_sat) begin
                n_errors++;
                $display("FAIL random_cycle%0d: out=%h valid=%b sat=%b required out=%h valid=%b sat=%b",
                         n, out, valid_out, sat_out, m_out, m_valid, m_sat);
            end
        end
    endtask

    initial begin
        m_a = '0; m_b = '0; m_out = '0; m_sat = '0; m_valid = 1'b0;
        p_v = 1'b0; p_acc = 1'b0; p_a = '0; p_b = '0; p_c = '0;
        idle_inputs();
        test_reset();
        test_basic();
        test_mac();
        test_saturation_rounding();
        test_held_operands();
        test_abort(1'b1);
        test_abort(1'b0);
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
